// File: rtl/atp_pkg.sv
// Shared constants, FSM state encoding and per-section speed limits for the ATP speed supervisor.
package atp_pkg;

    localparam int NUM_SECT = 12;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'b00;
    localparam state_t ST_MONITOR = 2'b01;
    localparam state_t ST_WARN    = 2'b10;
    localparam state_t ST_BRAKE   = 2'b11;

    // Minimum ticks a train must spend in a section; leaving sooner is overspeed.
    function automatic logic [15:0] sect_min(input logic [3:0] idx);
        if (idx < 4'd4) begin
            return 16'd200;
        end else if (idx < 4'd8) begin
            return 16'd100;
        end else begin
            return 16'd150;
        end
    endfunction

endpackage

// File: rtl/atp_interval_timer.sv
// Section traversal timer: saturating tick counter, cleared on every position step,
// capturing the completed count as the last interval.
module atp_interval_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             step,
    output logic [CNT_W-1:0] ivl_cnt,
    output logic [CNT_W-1:0] interval_o
);

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [CNT_W-1:0] ivl_d, ivl_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        ivl_d = ivl_q;
        if (step) begin
            ivl_d = cnt_q;
            cnt_d = '0;
        end else if (tick && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses <= so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            ivl_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            ivl_q <= ivl_d;
        end
    end

    assign ivl_cnt    = cnt_q;
    assign interval_o = ivl_q;

endmodule

// File: rtl/atp_speed_supervisor.sv
// ATP speed supervisor: section timing, overspeed detection and warn/ack/brake FSM.
// Optional overspeed event counter on port ovs_cnt when ATP_OVS_CNT_EN is defined.
module atp_speed_supervisor #(
    parameter int NUM_SECT   = atp_pkg::NUM_SECT,
    parameter int CNT_W      = 16,
    parameter int ACK_WINDOW = 500,
    parameter int STOP_TICKS = 2000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [3:0]       pos_in,
    input  logic             ack,
    output logic             warn,
    output logic             brake,
    output logic             fault,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] interval_o
`ifdef ATP_OVS_CNT_EN
    ,
    output logic [7:0]       ovs_cnt
`endif
);

    import atp_pkg::*;

    localparam logic [4:0] SECT_LIM = 5'(NUM_SECT);

    logic [3:0]       pos_q;
    state_t           state_d, state_q;
    logic             warn_d, warn_q;
    logic             brake_d, brake_q;
    logic             fault_d, fault_q;
    logic [CNT_W-1:0] ack_tmr_d, ack_tmr_q;
    logic [CNT_W-1:0] ivl_cnt;

    logic [4:0] pos_next;
    logic       out_of_range;
    logic       step;
    logic       legal;
    logic       illegal;
    logic       overspeed;

    assign pos_next     = {1'b0, pos_q} + 5'd1;
    assign out_of_range = ({1'b0, pos_in} >= SECT_LIM);
    assign step         = (pos_in != pos_q);
    assign legal        = step && ({1'b0, pos_in} == pos_next) && !out_of_range;
    assign illegal      = (step && !legal) || out_of_range;
    // Limit is that of the section being left, i.e. the registered position.
    assign overspeed    = legal && (ivl_cnt < CNT_W'(sect_min(pos_q)));

    atp_interval_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .step       (step),
        .ivl_cnt    (ivl_cnt),
        .interval_o (interval_o)
    );

    always_comb begin
        state_d   = state_q;
        ack_tmr_d = ack_tmr_q;
        fault_d   = fault_q | illegal;
        case (state_q)
            ST_IDLE: begin
                if (illegal)    state_d = ST_BRAKE;
                else if (legal) state_d = ST_MONITOR;
            end
            ST_MONITOR: begin
                if (illegal) begin
                    state_d = ST_BRAKE;
                end else if (overspeed) begin
                    state_d   = ST_WARN;
                    ack_tmr_d = CNT_W'(ACK_WINDOW);
                end
            end
            ST_WARN: begin
                if (illegal || overspeed) begin
                    state_d = ST_BRAKE;
                end else if (ack) begin
                    state_d = ST_MONITOR;
                end else if (tick) begin
                    ack_tmr_d = ack_tmr_q - CNT_W'(1);
                    if (ack_tmr_q <= CNT_W'(1)) state_d = ST_BRAKE;
                end
            end
            default: begin
                // A fault brake can only be released by reset.
                if (!illegal && !fault_q && ack && (ivl_cnt >= CNT_W'(STOP_TICKS)))
                    state_d = ST_IDLE;
            end
        endcase
        warn_d  = (state_d == ST_WARN);
        brake_d = (state_d == ST_BRAKE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_q     <= '0;
            state_q   <= ST_IDLE;
            warn_q    <= 1'b0;
            brake_q   <= 1'b0;
            fault_q   <= 1'b0;
            ack_tmr_q <= '0;
        end else begin
            pos_q     <= pos_in;
            state_q   <= state_d;
            warn_q    <= warn_d;
            brake_q   <= brake_d;
            fault_q   <= fault_d;
            ack_tmr_q <= ack_tmr_d;
        end
    end

    assign warn    = warn_q;
    assign brake   = brake_q;
    assign fault   = fault_q;
    assign state_o = state_q;

`ifdef ATP_OVS_CNT_EN
    logic       ovs_event;
    logic [7:0] ovs_cnt_d, ovs_cnt_q;

    assign ovs_event = overspeed && ((state_q == ST_MONITOR) || (state_q == ST_WARN));

    always_comb begin
        ovs_cnt_d = ovs_cnt_q;
        if (ovs_event && (ovs_cnt_q != 8'hFF)) ovs_cnt_d = ovs_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ovs_cnt_q <= '0;
        else      ovs_cnt_q <= ovs_cnt_d;
    end

    assign ovs_cnt = ovs_cnt_q;
`endif

endmodule

// File: tb/tb_atp_speed_supervisor.sv
// Self-checking bench for atp_speed_supervisor: directed scenarios plus randomized
// section traversals compared every cycle against a behavioural model.
module tb_atp_speed_supervisor;

    localparam int NUM_SECT   = 12;
    localparam int ACK_WINDOW = 500;
    localparam int STOP_TICKS = 2000;
    localparam int CNT_MAX    = 65535;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0;
    logic        ack = 1'b0;
    logic [3:0]  pos_in = 4'd0;
    logic        warn, brake, fault;
    logic [1:0]  state_o;
    logic [15:0] interval_o;
`ifdef ATP_OVS_CNT_EN
    logic [7:0]  ovs_cnt;
`endif

    atp_speed_supervisor dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .pos_in     (pos_in),
        .ack        (ack),
        .warn       (warn),
        .brake      (brake),
        .fault      (fault),
        .state_o    (state_o),
        .interval_o (interval_o)
`ifdef ATP_OVS_CNT_EN
        ,
        .ovs_cnt    (ovs_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state: mode 0 idle, 1 monitor, 2 warn, 3 brake.
    int m_pos, m_cnt, m_ivl, m_mode, m_fault, m_warn_ticks;
`ifdef ATP_OVS_CNT_EN
    int m_ovs;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
            if (failures >= 50) begin
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    endtask

    function automatic int section_limit(input int p);
        if (p < 4) return 200;
        if (p < 8) return 100;
        return 150;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_cnt = 0; m_ivl = 0; m_mode = 0; m_fault = 0; m_warn_ticks = 0;
`ifdef ATP_OVS_CNT_EN
        m_ovs = 0;
`endif
    endtask

    task automatic model_edge(input bit t, input int p, input bit a);
        bit moved = (p != m_pos);
        bit good  = moved && (p == m_pos + 1) && (p < NUM_SECT);
        bit bad   = (moved && !good) || (p >= NUM_SECT);
        bit fast  = good && (m_cnt < section_limit(m_pos));
        case (m_mode)
            0: if (bad) m_mode = 3; else if (good) m_mode = 1;
            1: if (bad) m_mode = 3;
               else if (fast) begin
                   m_mode = 2; m_warn_ticks = 0;
`ifdef ATP_OVS_CNT_EN
                   if (m_ovs < 255) m_ovs++;
`endif
               end
            2: if (bad) m_mode = 3;
               else if (fast) begin
                   m_mode = 3;
`ifdef ATP_OVS_CNT_EN
                   if (m_ovs < 255) m_ovs++;
`endif
               end else if (a) m_mode = 1;
               else if (t) begin
                   m_warn_ticks++;
                   if (m_warn_ticks >= ACK_WINDOW) m_mode = 3;
               end
            default: if (!bad && (m_fault == 0) && a && (m_cnt >= STOP_TICKS)) m_mode = 0;
        endcase
        if (bad) m_fault = 1;
        if (moved) begin
            m_ivl = m_cnt; m_cnt = 0;
        end else if (t && (m_cnt < CNT_MAX)) begin
            m_cnt++;
        end
        m_pos = p;
    endtask

    task automatic compare_all();
        check("outputs{state,warn,brake,fault}", {27'd0, state_o, warn, brake, fault},
              {27'd0, 2'(m_mode), m_mode == 2, m_mode == 3, m_fault != 0});
        check("interval_o", {16'd0, interval_o}, m_ivl);
`ifdef ATP_OVS_CNT_EN
        check("ovs_cnt", {24'd0, ovs_cnt}, m_ovs);
`endif
    endtask

    task automatic cyc(input bit t, input int p, input bit a);
        tick = t; pos_in = 4'(p); ack = a;
        @(posedge clk);
        model_edge(t, p, a);
        #1;
        compare_all();
    endtask

    task automatic hold(input int n, input int p, input bit a);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, p, a);
            cyc(1'b0, p, a);
        end
    endtask

    task automatic do_reset();
        tick = 1'b0; ack = 1'b0; pos_in = 4'd0;
        rst = 1'b0;
        #1;
        model_reset();
        check("async_reset_outputs", {11'd0, state_o, warn, brake, fault, interval_o}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int pos, dwell;

        // 1: legal traversal with slow sections
        do_reset();
        hold(250, 0, 0); cyc(0, 1, 0);
        hold(250, 1, 0); cyc(0, 2, 0);
        hold(250, 2, 0); cyc(0, 3, 0);
        check("t1_state", state_o, 1);
        check("t1_warn", warn, 0);
        check("t1_interval", interval_o, 250);

        // 2: leave section 5 too early, then acknowledge
        hold(250, 3, 0); cyc(0, 4, 0);
        hold(250, 4, 0); cyc(0, 5, 0);
        hold(60, 5, 0);  cyc(0, 6, 0);
        check("t2_warn", warn, 1);
        check("t2_state", state_o, 2);
        hold(10, 6, 0);  cyc(0, 6, 1);
        check("t2_ack_state", state_o, 1);
        check("t2_ack_warn", warn, 0);
        cyc(0, 6, 0);

        // 3: overspeed without ack times out to brake, then standstill release
        cyc(0, 7, 0);
        check("t3_warn_state", state_o, 2);
        hold(499, 7, 0);
        check("t3_before_timeout", state_o, 2);
        hold(1, 7, 0);
        check("t3_brake", brake, 1);
        check("t3_brake_state", state_o, 3);
        hold(2000, 7, 0); cyc(0, 7, 1);
        check("t3_release_state", state_o, 0);
        check("t3_release_brake", brake, 0);

        // 4: jump fault is only cleared by reset
        do_reset();
        cyc(0, 1, 0); hold(250, 1, 0);
        cyc(0, 2, 0); hold(250, 2, 0);
        cyc(0, 3, 0); hold(20, 3, 0);
        cyc(0, 5, 0);
        check("t4_fault", fault, 1);
        check("t4_brake", brake, 1);
        hold(2000, 5, 0); cyc(0, 5, 1);
        check("t4_still_brake", brake, 1);
        cyc(0, 5, 0);
        rst = 1'b0; #1;
        check("t4_midop_reset_brake", brake, 0);
        do_reset();

        // 5: out-of-range position, then ack racing the timeout
        cyc(0, 1, 0); hold(10, 1, 0);
        cyc(0, 12, 0);
        check("t5_range_fault", fault, 1);
        check("t5_range_brake", brake, 1);
        do_reset();
        cyc(0, 1, 0); hold(5, 1, 0);
        cyc(0, 2, 0);
        check("t5_warn_state", state_o, 2);
        hold(499, 2, 0);
        cyc(1, 2, 1);
        check("t5_ack_beats_timeout", state_o, 1);

`ifdef ATP_OVS_CNT_EN
        // 6: overspeed event counter
        do_reset();
        cyc(0, 1, 0); hold(5, 1, 0);
        cyc(0, 2, 0); cyc(0, 2, 1); cyc(0, 2, 0);
        cyc(0, 3, 0); cyc(0, 3, 1); cyc(0, 3, 0);
        check("t6_ovs_cnt", ovs_cnt, 2);
`endif

        // Randomized traversals with occasional illegal moves and long stops
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            pos = 0;
            for (int s = 0; s < 12; s++) begin
                dwell = ($urandom_range(0, 7) == 0) ? $urandom_range(1900, 2200)
                                                    : $urandom_range(20, 260);
                for (int i = 0; i < dwell; i++)
                    cyc($urandom_range(0, 3) != 0, pos, $urandom_range(0, 7) == 0);
                if ($urandom_range(0, 9) == 0) pos = $urandom_range(0, 15);
                else if (pos < NUM_SECT - 1) pos++;
                cyc(1'b0, pos, 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
